fp32_divider: RTL and testbench
===============================

# fp32_divider

Sequential IEEE-754 single-precision divider computing `output_z = input_a / input_b` with a restoring radix-2 quotient loop and round-to-nearest-even. It is the inverse-operation companion to the core's FP32 multiplier and shares its operand and result port naming. It adds an explicit start/busy/done handshake, so a controller can issue back-to-back operations without pulsing reset.

## Interface
- No parameters.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset; sampled on rising edge of `clk`.
- `start`  input  1  operation request; sampled only in IDLE.
- `input_a`  input  32  dividend (IEEE-754 binary32), latched when `start` is accepted.
- `input_b`  input  32  divisor (IEEE-754 binary32), latched when `start` is accepted.
- `output_z`  output  32  quotient; valid from the `done` cycle until the next accepted `start`.
- `done`  output  1  one-cycle pulse when `output_z` becomes valid.
- `busy`  output  1  high from the cycle after `start` is accepted through the `done` cycle.

## Operation
- States: IDLE, SPECIAL, PRENORM (only with macro), DIVIDE, NORMALISE, PACK, DONE.
- IDLE: if `start`=1, latch operands and go to SPECIAL. Otherwise hold.
- SPECIAL: sign = a[31]^b[31]. Priority order:
  - Either operand NaN, 0/0, or inf/inf → 0x7FC00000 (sign 0).
  - inf/x or x/0 → signed inf.
  - 0/x or x/inf → signed zero.
  - Otherwise unpack mantissas with the hidden bit to 24 bits and go to PRENORM or DIVIDE.
- Exponent: 10-bit signed, `z_e = a_e - b_e + 127`.
- DIVIDE, 27 iterations, one per cycle. Remainder `r` is 26 bits, initialised to `a_m`.
  - Each cycle: if `r >= b_m`, shift in quotient bit 1 and set `r -= b_m`; else shift in 0.
  - Then `r <<= 1`.
  - Result is `q[26:0]`.
- NORMALISE:
  - If `q[26]`=0: `q <<= 1` and `z_e -= 1`.
  - Mantissa = `q[25:3]`, guard = `q[2]`, round = `q[1]`, sticky = `q[0] | (r != 0)`.
- PACK:
  - Apply RNE: increment if guard & (round | sticky | lsb).
  - Mantissa carry-out increments `z_e`.
  - `z_e >= 255` → signed inf.
  - `z_e <= 0` → underflow handling (see Configuration).
  - Otherwise pack `{sign, z_e[7:0], mant}`.
- DONE: `done`=1 for exactly one cycle, then return to IDLE. `output_z` holds.
- `start` is ignored while `busy`=1.
- `rst` and `start` in the same cycle: reset wins and the operation is not accepted.
- Reset mid-operation: abort immediately, no `done` pulse.

## Timing
- Reset values: `output_z`=0x00000000, `done`=0, `busy`=0, state IDLE.
- With `start` accepted at edge T:
  - SPECIAL at T+1.
  - Special-case result: `done`=1 at T+2.
  - Normal path: DIVIDE T+2..T+28, NORMALISE T+29, PACK T+30, `done`=1 at T+31.
- PRENORM adds k cycles, where k is the total leading-zero shift of denormal inputs (0 when both inputs are normal).
- Next `start` is accepted in the cycle after DONE (IDLE). Minimum issue interval is 32 cycles on the normal path.

## Configuration
- Macro `FP32_DIV_DENORM_EN`.
- Defined:
  - Denormal inputs get exponent 1 and hidden bit 0.
  - PRENORM shifts the mantissa left one bit per cycle, decrementing the exponent, until bit 23 = 1.
  - Results with `z_e <= 0` are right-shifted by `1 - z_e` in PACK, with shifted-out bits ORed into sticky, then RNE is applied. Exponent field is 0, or 1 if rounding carries into bit 23.
  - Shift amounts ≥ 25 give signed zero.
- Undefined:
  - PRENORM is absent; denormal inputs are treated as signed zero (0/0 → NaN, x/denorm → inf).
  - Results with `z_e <= 0` flush to signed zero.

## Test plan
- 0x40C00000 / 0x40000000 (6.0/2.0), `start` at T → `output_z`=0x40400000, `done` pulse at T+31, `busy` high T+1..T+31.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB (RNE round-up). 0xBF800000 / 0x40400000 → 0xBEAAAAAB.
- Special cases, each with `done` at T+2:
  - 0x3F800000 / 0x00000000 → 0x7F800000.
  - 0x00000000 / 0x00000000 → 0x7FC00000.
  - 0x7F800000 / 0xC0000000 → 0xFF800000.
  - 0x7FC00001 / 0x3F800000 → 0x7FC00000.
- Overflow: 0x7F000000 / 0x3E800000 → 0x7F800000.
- Underflow: 0x00800000 / 0x40000000.
  - With `FP32_DIV_DENORM_EN`: 0x00400000, 2 PRENORM cycles not needed, `done` at T+31.
  - Without: 0x00000000.
  - Also 0x00000001 / 0x3F800000 with the macro → 0x00000001 after 23 PRENORM cycles.
- Robustness:
  - Assert `rst` at T+10 of a divide: `busy`=0, `done`=0, `output_z`=0 next cycle, no `done` pulse.
  - `start` pulsed at T+5 while busy is ignored and the result is unchanged.
  - `rst`+`start` together: no operation starts.

Source files
------------

// File: rtl/fp32_divider.sv
`default_nettype none
// ============================================================================
// Module      : fp32_divider
// Description : Sequential IEEE-754 binary32 divider, output_z = input_a /
//               input_b. Restoring radix-2 quotient loop (27 iterations,
//               one per cycle) followed by round-to-nearest-even.
//               start/busy/done handshake allows back-to-back issue.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1   clock, all state changes on rising edge
//   rst       in   1   synchronous active-high reset
//   start     in   1   operation request, sampled only while idle
//   input_a   in  32   dividend, latched when start is accepted
//   input_b   in  32   divisor, latched when start is accepted
//   output_z  out 32   quotient, valid from done until the next accepted start
//   done      out  1   single-cycle pulse when output_z becomes valid
//   busy      out  1   high from the cycle after start through the done cycle
// ----------------------------------------------------------------------------
// Configuration macro
//   FP32_DIV_DENORM_EN : when defined, denormal operands are normalised in a
//                        PRENORM state and tiny results are produced as
//                        rounded denormals. When undefined, denormal operands
//                        are treated as signed zero and tiny results flush
//                        to signed zero.
// ============================================================================
module fp32_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    output logic [31:0] output_z,
    output logic        done,
    output logic        busy
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_SPECIAL   = 3'd1;
`ifdef FP32_DIV_DENORM_EN
    localparam logic [2:0] c_PRENORM   = 3'd2;
`endif
    localparam logic [2:0] c_DIVIDE    = 3'd3;
    localparam logic [2:0] c_NORMALISE = 3'd4;
    localparam logic [2:0] c_PACK      = 3'd5;
    localparam logic [2:0] c_DONE      = 3'd6;

    // Index of the last quotient iteration (27 iterations: 0..26)
    localparam logic [4:0] c_LAST_ITER = 5'd26;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic              r_sign;
    logic signed [9:0] r_z_e;
    logic [25:0]       r_rem;     // partial remainder; holds a_m before DIVIDE
    logic [23:0]       r_b_m;
    logic [26:0]       r_q;
    logic [4:0]        r_cnt;
    logic [31:0]       r_z;

    // ------------------------------------------------------------------------
    // Operand classification (from the latched operands)
    // ------------------------------------------------------------------------
    logic [7:0]  w_a_e;
    logic [7:0]  w_b_e;
    logic [22:0] w_a_f;
    logic [22:0] w_b_f;
    logic        w_a_nan;
    logic        w_b_nan;
    logic        w_a_inf;
    logic        w_b_inf;
    logic        w_a_zero;
    logic        w_b_zero;
    logic [23:0] w_a_sig;
    logic [23:0] w_b_sig;
    logic [9:0]  w_a_exp;
    logic [9:0]  w_b_exp;
    logic        w_sign;

    assign w_a_e   = r_a[30:23];
    assign w_b_e   = r_b[30:23];
    assign w_a_f   = r_a[22:0];
    assign w_b_f   = r_b[22:0];
    assign w_sign  = r_a[31] ^ r_b[31];

    assign w_a_nan = (&w_a_e) & (|w_a_f);
    assign w_b_nan = (&w_b_e) & (|w_b_f);
    assign w_a_inf = (&w_a_e) & ~(|w_a_f);
    assign w_b_inf = (&w_b_e) & ~(|w_b_f);

`ifdef FP32_DIV_DENORM_EN
    assign w_a_zero = ~(|r_a[30:0]);
    assign w_b_zero = ~(|r_b[30:0]);
`else
    // A zero exponent field (true zero or denormal) counts as zero.
    assign w_a_zero = ~(|w_a_e);
    assign w_b_zero = ~(|w_b_e);
`endif

    // Denormals carry exponent 1 and a clear hidden bit.
    assign w_a_sig = {|w_a_e, w_a_f};
    assign w_b_sig = {|w_b_e, w_b_f};
    assign w_a_exp = (|w_a_e) ? {2'b00, w_a_e} : 10'd1;
    assign w_b_exp = (|w_b_e) ? {2'b00, w_b_e} : 10'd1;

    // Special-case result, in priority order.
    logic        w_is_special;
    logic [31:0] w_special_z;

    always_comb begin
        w_is_special = 1'b1;
        w_special_z  = 32'h7FC0_0000;
        if (w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) begin
            w_special_z = 32'h7FC0_0000;
        end else if (w_a_inf | w_b_zero) begin
            w_special_z = {w_sign, 8'hFF, 23'd0};
        end else if (w_a_zero | w_b_inf) begin
            w_special_z = {w_sign, 31'd0};
        end else begin
            w_is_special = 1'b0;
        end
    end

`ifdef FP32_DIV_DENORM_EN
    // Normalisation shifts the dividend first, then the divisor. The lookahead
    // tells whether the shift happening this cycle is the final one.
    logic w_need_prenorm;
    logic w_pre_last;

    assign w_need_prenorm = ~(w_a_sig[23] & w_b_sig[23]);
    assign w_pre_last     = r_rem[23] ? r_b_m[22] : (r_rem[22] & r_b_m[23]);
`endif

    // ------------------------------------------------------------------------
    // Restoring divide step
    // ------------------------------------------------------------------------
    logic        w_ge;
    logic [25:0] w_diff;
    logic [25:0] w_rem_sel;
    logic [25:0] w_rem_next;

    assign w_ge       = (r_rem >= {2'b00, r_b_m});
    assign w_diff     = r_rem - {2'b00, r_b_m};
    assign w_rem_sel  = w_ge ? w_diff : r_rem;
    assign w_rem_next = w_rem_sel << 1;

    // ------------------------------------------------------------------------
    // Rounding and packing (normal-range result)
    // ------------------------------------------------------------------------
    logic [23:0]       w_sig24;
    logic              w_guard;
    logic              w_rnd;
    logic              w_sticky;
    logic              w_up;
    logic [23:0]       w_sum;
    logic signed [9:0] w_z_post;
    logic [31:0]       w_norm_z;
    logic [31:0]       w_pack_z;

    assign w_sig24  = r_q[26:3];
    assign w_guard  = r_q[2];
    assign w_rnd    = r_q[1];
    assign w_sticky = r_q[0] | (|r_rem);
    assign w_up     = w_guard & (w_rnd | w_sticky | w_sig24[0]);
    assign w_sum    = w_sig24 + {23'd0, w_up};

    // The hidden bit is set before rounding, so a clear bit 23 after the
    // increment means the significand wrapped to 2.0 (mantissa becomes 0).
    assign w_z_post = r_z_e + $signed({9'd0, ~w_sum[23]});

    always_comb begin
        w_norm_z = {r_sign, w_z_post[7:0], w_sum[22:0]};
        if (w_z_post >= 10'sd255) begin
            w_norm_z = {r_sign, 8'hFF, 23'd0};
        end else if (w_z_post <= 10'sd0) begin
            w_norm_z = {r_sign, 31'd0};
        end
    end

`ifdef FP32_DIV_DENORM_EN
    // ------------------------------------------------------------------------
    // Denormal result: shift {significand, guard, round} right by 1 - z_e,
    // fold the bits that fall off into sticky, then round. A carry out of the
    // 23-bit field lands in the exponent LSB, giving the smallest normal.
    // ------------------------------------------------------------------------
    logic signed [9:0] w_sh;
    logic              w_sh_big;
    logic [4:0]        w_sh5;
    logic [25:0]       w_v;
    logic [25:0]       w_mask;
    logic [25:0]       w_v_sh;
    logic              w_dsticky;
    logic [23:0]       w_dsig;
    logic              w_dup;
    logic [23:0]       w_dsum;
    logic [31:0]       w_denorm_z;

    assign w_sh       = 10'sd1 - r_z_e;
    assign w_sh_big   = (w_sh >= 10'sd25);
    assign w_sh5      = w_sh[4:0];
    assign w_v        = r_q[26:1];
    assign w_mask     = (26'd1 << w_sh5) - 26'd1;
    assign w_v_sh     = w_v >> w_sh5;
    assign w_dsticky  = w_sticky | (|(w_v & w_mask));
    assign w_dsig     = w_v_sh[25:2];
    assign w_dup      = w_v_sh[1] & (w_v_sh[0] | w_dsticky | w_dsig[0]);
    assign w_dsum     = w_dsig + {23'd0, w_dup};
    assign w_denorm_z = {r_sign, 7'd0, w_dsum};

    always_comb begin
        w_pack_z = w_norm_z;
        if (r_z_e <= 10'sd0) begin
            w_pack_z = w_sh_big ? {r_sign, 31'd0} : w_denorm_z;
        end
    end
`else
    assign w_pack_z = w_norm_z;
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_next = c_SPECIAL;
                end
            end
            c_SPECIAL: begin
                if (w_is_special) begin
                    w_state_next = c_DONE;
                end else begin
`ifdef FP32_DIV_DENORM_EN
                    w_state_next = w_need_prenorm ? c_PRENORM : c_DIVIDE;
`else
                    w_state_next = c_DIVIDE;
`endif
                end
            end
`ifdef FP32_DIV_DENORM_EN
            c_PRENORM: begin
                if (w_pre_last) begin
                    w_state_next = c_DIVIDE;
                end
            end
`endif
            c_DIVIDE: begin
                if (r_cnt == c_LAST_ITER) begin
                    w_state_next = c_NORMALISE;
                end
            end
            c_NORMALISE: w_state_next = c_PACK;
            c_PACK:      w_state_next = c_DONE;
            c_DONE:      w_state_next = c_IDLE;
            default:     w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sign <= 1'b0;
            r_z_e  <= '0;
            r_rem  <= '0;
            r_b_m  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_z    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a <= input_a;
                        r_b <= input_b;
                    end
                end
                c_SPECIAL: begin
                    r_sign <= w_sign;
                    r_z_e  <= $signed(w_a_exp - w_b_exp + 10'd127);
                    r_rem  <= {2'b00, w_a_sig};
                    r_b_m  <= w_b_sig;
                    r_q    <= '0;
                    r_cnt  <= '0;
                    if (w_is_special) begin
                        r_z <= w_special_z;
                    end
                end
`ifdef FP32_DIV_DENORM_EN
                c_PRENORM: begin
                    // Shifting the dividend lowers z_e; shifting the divisor raises it.
                    if (!r_rem[23]) begin
                        r_rem <= r_rem << 1;
                        r_z_e <= r_z_e - 10'sd1;
                    end else begin
                        r_b_m <= r_b_m << 1;
                        r_z_e <= r_z_e + 10'sd1;
                    end
                end
`endif
                c_DIVIDE: begin
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[25:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                end
                c_NORMALISE: begin
                    if (!r_q[26]) begin
                        r_q   <= {r_q[25:0], 1'b0};
                        r_z_e <= r_z_e - 10'sd1;
                    end
                end
                c_PACK: begin
                    r_z <= w_pack_z;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign output_z = r_z;
    assign done     = (r_state == c_DONE);
    assign busy     = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fp32_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp32_divider
// Description : Self-checking bench for fp32_divider. Directed vectors with
//               fixed expected values, randomized operands checked against an
//               arithmetic reference model, plus handshake/reset scenarios.
//               Honours FP32_DIV_DENORM_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic [31:0] output_z;
    logic        done;
    logic        busy;

    int checks;
    int errors;

    fp32_divider u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .input_a  (input_a),
        .input_b  (input_b),
        .output_z (output_z),
        .done     (done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        int          lat;
    } vec_t;

    // ------------------------------------------------------------------------
    // Reference model: exact integer quotient of the significands scaled by
    // 2^26, then normalisation and round-to-nearest-even by plain arithmetic.
    // lat is the number of rising edges from start acceptance to done.
    // ------------------------------------------------------------------------
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            output int lat);
        logic   s;
        int     ea, eb, fa, fb, z, k, sh;
        bit     an, bn, ai, bi, az, bz, g, rb, st, up;
        longint ma, mb, num, q, rem, sig, v, rounded;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = int'(a[22:0]);
        fb = int'(b[22:0]);
        an = (ea == 255) && (fa != 0);
        bn = (eb == 255) && (fb != 0);
        ai = (ea == 255) && (fa == 0);
        bi = (eb == 255) && (fb == 0);
`ifdef FP32_DIV_DENORM_EN
        az = (ea == 0) && (fa == 0);
        bz = (eb == 0) && (fb == 0);
`else
        az = (ea == 0);
        bz = (eb == 0);
`endif
        lat = 2;
        if (an || bn || (az && bz) || (ai && bi)) return 32'h7FC00000;
        if (ai || bz) return {s, 8'hFF, 23'd0};
        if (az || bi) return {s, 31'd0};

        k = 0;
        if (ea == 0) begin ma = longint'(fa); ea = 1; end
        else         ma = longint'(fa) + 64'd8388608;
        if (eb == 0) begin mb = longint'(fb); eb = 1; end
        else         mb = longint'(fb) + 64'd8388608;
        while (ma < 64'd8388608) begin ma = ma * 2; ea = ea - 1; k = k + 1; end
        while (mb < 64'd8388608) begin mb = mb * 2; eb = eb - 1; k = k + 1; end
        lat = 31 + k;

        z   = ea - eb + 127;
        num = ma * 64'd67108864;
        q   = num / mb;
        rem = num % mb;
        if (q < 64'd67108864) begin q = q * 2; z = z - 1; end
        st = ((q % 2) != 0) || (rem != 0);

`ifdef FP32_DIV_DENORM_EN
        if (z <= 0) begin
            sh = 1 - z;
            if (sh >= 25) return {s, 31'd0};
            v = q / 2;
            if ((v % (64'd1 << sh)) != 0) st = 1'b1;
            v   = v >> sh;
            sig = v / 4;
            g   = ((v / 2) % 2) != 0;
            rb  = (v % 2) != 0;
            up  = g && (rb || st || ((sig % 2) != 0));
            rounded = sig + (up ? 64'd1 : 64'd0);
            return {s, 31'(rounded)};
        end
`endif
        sig = q / 8;
        g   = ((q / 4) % 2) != 0;
        rb  = ((q / 2) % 2) != 0;
        up  = g && (rb || st || ((sig % 2) != 0));
        rounded = sig + (up ? 64'd1 : 64'd0);
        if (rounded >= 64'd16777216) begin rounded = rounded / 2; z = z + 1; end
        if (z >= 255) return {s, 8'hFF, 23'd0};
        if (z <= 0)   return {s, 31'd0};
        return {s, 8'(z), 23'(rounded % 64'd8388608)};
    endfunction

    // ------------------------------------------------------------------------
    // Driver: call at a negedge with the DUT idle. Issues one operation,
    // optionally re-pulses start at inj_at cycles in, and returns the result,
    // the observed latency (-1 if done never arrived) and a handshake flag
    // (busy high through done, done single-cycle, result held afterwards).
    // Returns at the negedge after done, where the DUT is idle again.
    // ------------------------------------------------------------------------
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inj_at,
                          output logic [31:0] z, output int lat, output bit hs_ok);
        int cnt;
        bit seen;
        start   = 1'b1;
        input_a = a;
        input_b = b;
        hs_ok   = 1'b1;
        lat     = -1;
        cnt     = 0;
        seen    = 1'b0;
        z       = 32'hx;
        while (!seen && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) start = 1'b0;
            if (inj_at != 0 && cnt == inj_at) begin
                start   = 1'b1;
                input_a = 32'h3F800000;
                input_b = 32'h40400000;
            end
            if (inj_at != 0 && cnt == inj_at + 1) start = 1'b0;
            if (busy !== 1'b1) hs_ok = 1'b0;
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = cnt;
                z    = output_z;
            end
        end
        start = 1'b0;
        @(negedge clk);
        if (busy !== 1'b0 || done !== 1'b0 || output_z !== z) hs_ok = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (output_z !== 32'h0) begin
            errors++;
            $display("FAIL reset_output_z: got %h expected 00000000", output_z);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        vec_t        vecs[$];
        logic [31:0] z;
        int          lat;
        bit          ok;
        vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, 31});
        vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 31});
        vecs.push_back('{32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 31});
        vecs.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000, 2});
        vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 2});
        vecs.push_back('{32'h7F800000, 32'hC0000000, 32'hFF800000, 2});
        vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2});
        vecs.push_back('{32'h7F800000, 32'h7F800000, 32'h7FC00000, 2});
        vecs.push_back('{32'h00000000, 32'h7F800000, 32'h00000000, 2});
        vecs.push_back('{32'hC0000000, 32'h7F800000, 32'h80000000, 2});
        vecs.push_back('{32'h7F000000, 32'h3E800000, 32'h7F800000, 31});
`ifdef FP32_DIV_DENORM_EN
        vecs.push_back('{32'h00800000, 32'h40000000, 32'h00400000, 31});
        vecs.push_back('{32'h00000001, 32'h3F800000, 32'h00000001, 54});
        vecs.push_back('{32'h3F800000, 32'h00000001, 32'h7F800000, 54});
`else
        vecs.push_back('{32'h00800000, 32'h40000000, 32'h00000000, 31});
        vecs.push_back('{32'h00000001, 32'h3F800000, 32'h00000000, 2});
        vecs.push_back('{32'h3F800000, 32'h00000001, 32'h7F800000, 2});
        vecs.push_back('{32'h80000001, 32'h3F800000, 32'h80000000, 2});
`endif
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, 0, z, lat, ok);
            checks++;
            if (z !== vecs[i].z) begin
                errors++;
                $display("FAIL directed_%0d_result %h/%h: got %h expected %h",
                         i, vecs[i].a, vecs[i].b, z, vecs[i].z);
            end
            checks++;
            if (lat !== vecs[i].lat) begin
                errors++;
                $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat, vecs[i].lat);
            end
            checks++;
            if (ok !== 1'b1) begin
                errors++;
                $display("FAIL directed_%0d_handshake: got %b expected 1", i, ok);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] z;
        int          lat;
        bit          ok;
        run_op(32'h40C00000, 32'h40000000, 4, z, lat, ok);
        checks++;
        if (z !== 32'h40400000) begin
            errors++;
            $display("FAIL busy_ignore_result: got %h expected 40400000", z);
        end
        checks++;
        if (lat !== 31) begin
            errors++;
            $display("FAIL busy_ignore_latency: got %0d expected 31", lat);
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL busy_ignore_handshake: got %b expected 1", ok);
        end
    endtask

    // Consecutive run_op calls issue start in the first idle cycle after done,
    // so correct latencies here also confirm the 32-cycle issue interval.
    task automatic test_back_to_back();
        logic [31:0] a_q[3] = '{32'h41200000, 32'hC1100000, 32'h3F800000};
        logic [31:0] b_q[3] = '{32'h40A00000, 32'h40400000, 32'h3F800000};
        logic [31:0] e_q[3] = '{32'h40000000, 32'hC0400000, 32'h3F800000};
        logic [31:0] z;
        int          lat;
        bit          ok;
        for (int i = 0; i < 3; i++) begin
            run_op(a_q[i], b_q[i], 0, z, lat, ok);
            checks++;
            if (z !== e_q[i] || lat !== 31 || ok !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back_%0d: got %h lat %0d hs %b expected %h lat 31 hs 1",
                         i, z, lat, ok, e_q[i]);
            end
        end
    endtask

    function automatic logic [31:0] rand_operand();
        int          sel;
        logic [31:0] w;
        sel = $urandom_range(0, 9);
        w   = $urandom;
        if (sel < 5) begin
            w[30:23] = 8'($urandom_range(100, 154));
        end else if (sel == 5) begin
            w[30:23] = 8'd0;
            if ($urandom_range(0, 3) == 0) w[22:0] = 23'd0;
        end else if (sel == 6) begin
            w[30:23] = 8'hFF;
            if ($urandom_range(0, 1) == 1) w[22:0] = 23'd0;
        end else if (sel == 7) begin
            w[30:23] = 8'($urandom_range(1, 3));
        end else if (sel == 8) begin
            w[30:23] = 8'($urandom_range(252, 254));
        end
        return w;
    endfunction

    task automatic test_random();
        logic [31:0] a, b, z, exp_z;
        int          lat, exp_lat;
        bit          ok;
        for (int n = 0; n < 160; n++) begin
            a     = rand_operand();
            b     = rand_operand();
            exp_z = ref_div(a, b, exp_lat);
            run_op(a, b, 0, z, lat, ok);
            checks++;
            if (z !== exp_z) begin
                errors++;
                $display("FAIL random_%0d_result %h/%h: got %h expected %h", n, a, b, z, exp_z);
            end
            checks++;
            if (lat !== exp_lat || ok !== 1'b1) begin
                errors++;
                $display("FAIL random_%0d_timing %h/%h: got lat %0d hs %b expected lat %0d hs 1",
                         n, a, b, lat, ok, exp_lat);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] z;
        int          lat;
        bit          ok;
        bit          saw;
        run_op(32'h40C00000, 32'h40000000, 0, z, lat, ok);
        start   = 1'b1;
        input_a = 32'h3F800000;
        input_b = 32'h40400000;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || output_z !== 32'h0) begin
            errors++;
            $display("FAIL reset_midop_state: got busy %b done %b z %h expected busy 0 done 0 z 00000000",
                     busy, done, output_z);
        end
        rst = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop_no_done: got activity %b expected 0", saw);
        end
    endtask

    task automatic test_rst_start();
        logic [31:0] z;
        int          lat;
        bit          ok;
        run_op(32'h40C00000, 32'h40000000, 0, z, lat, ok);
        rst     = 1'b1;
        start   = 1'b1;
        input_a = 32'h3F800000;
        input_b = 32'h40400000;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || output_z !== 32'h0) begin
            errors++;
            $display("FAIL rst_start_same_cycle: got busy %b z %h expected busy 0 z 00000000",
                     busy, output_z);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_start_no_op: got busy %b expected 0", busy);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        input_a = '0;
        input_b = '0;
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_midop();
        test_rst_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
